// File: rtl/counter_arbiter_ctrl.sv
// Round-robin owner of one shared external up-counter: clears it, enables it until the
// owner's terminal count is reached, then pulses that owner's done.
module counter_arbiter_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] tc0,
   input  logic [WIDTH-1:0] tc1,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_en,
   output logic             cnt_clr,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             owner;
   logic             owner_nxt;
   logic             last;
   logic             last_nxt;
   logic [WIDTH-1:0] tc_r;
   logic [WIDTH-1:0] tc_nxt;
   logic             pick;
   logic             at_tc;

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         tc_r  <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         tc_r  <= tc_nxt;
      end
   end

   assign at_tc = (cnt_q == tc_r);

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      tc_nxt    = tc_r;
      pick      = 1'b0;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      busy      = (state != IDLE);

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               // With both requesting, the one that did not win last time goes next.
               pick      = (req0 && req1) ? ~last : req1;
               owner_nxt = pick;
               last_nxt  = pick;
               tc_nxt    = pick ? tc1 : tc0;
               state_nxt = CLR;
            end
         end
         CLR: begin
            cnt_clr   = 1'b1;
            gnt0      = ~owner;
            gnt1      = owner;
            state_nxt = abort ? IDLE : RUN;
         end
         RUN: begin
            gnt0   = ~owner;
            gnt1   = owner;
            cnt_en = ~at_tc & ~abort;
            if (abort)
               state_nxt = IDLE;
            else if (at_tc)
               state_nxt = DONE;
         end
         DONE: begin
            done0     = ~owner;
            done1     = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Reset wins over everything, including the outputs of the cycle it is asserted in.
      if (clear) begin
         cnt_en  = 1'b0;
         cnt_clr = 1'b0;
         gnt0    = 1'b0;
         gnt1    = 1'b0;
         done0   = 1'b0;
         done1   = 1'b0;
         busy    = 1'b0;
      end
   end

endmodule

// File: tb/tb_counter_arbiter_ctrl.sv
// Directed bench for counter_arbiter_ctrl with a behavioural shared counter and a
// scoreboard of expected run completions (owner, increments, final count).
module tb_counter_arbiter_ctrl;

   localparam int WIDTH = 4;

   logic             clock;
   logic             clear;
   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] tc0;
   logic [WIDTH-1:0] tc1;
   logic             abort;
   logic [WIDTH-1:0] cnt_q = '0;
   logic             cnt_en;
   logic             cnt_clr;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic             busy;

   typedef struct {
      logic owner;
      int   en;
      int   q;
   } exp_t;

   exp_t sb[$];
   logic gnt_order[$];
   exp_t mon_e;
   int   en_cnt = 0;
   bit   gnt1_seen = 0;
   int   n_assert = 0;
   int   n_fail = 0;

   counter_arbiter_ctrl #(.WIDTH(WIDTH)) dut (
      .clock  (clock),
      .clear  (clear),
      .req0   (req0),
      .req1   (req1),
      .tc0    (tc0),
      .tc1    (tc1),
      .abort  (abort),
      .cnt_q  (cnt_q),
      .cnt_en (cnt_en),
      .cnt_clr(cnt_clr),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .done0  (done0),
      .done1  (done1),
      .busy   (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // The shared counter the block controls
   always @(posedge clock) begin
      if (cnt_clr)
         cnt_q <= '0;
      else if (cnt_en)
         cnt_q <= cnt_q + 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] outs();
      return {cnt_en, cnt_clr, gnt0, gnt1, done0, done1, busy};
   endfunction

   // Monitor: count increments per run, record grant order, score each done pulse
   always @(negedge clock) begin
      if (cnt_clr === 1'b1) begin
         en_cnt = 0;
         gnt_order.push_back(gnt1);
      end else if (cnt_en === 1'b1) begin
         en_cnt++;
      end
      if (gnt1 === 1'b1) gnt1_seen = 1;
      check("gnt_onehot", {31'd0, gnt0 & gnt1}, 0);
      check("done_onehot", {31'd0, done0 & done1}, 0);
      if (done0 === 1'b1 || done1 === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("sb_owner", {31'd0, done1}, {31'd0, mon_e.owner});
            check("sb_en_cycles", en_cnt, mon_e.en);
            check("sb_cnt_q", {28'd0, cnt_q}, mon_e.q);
         end
      end
   end

   task automatic wait_done(input string tag, input int exp_lat);
      int k = 0;
      bit got = 0;
      while (!got && k < 40) begin
         @(negedge clock);
         k++;
         if (done0 === 1'b1 || done1 === 1'b1) got = 1;
      end
      if (got) check({tag, "_latency"}, k, exp_lat);
      else     check({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      clear = 1'b1; req0 = 1'b1; req1 = 1'b0; tc0 = 4'd5; tc1 = 4'd0; abort = 1'b0;

      // Reset held two cycles with a request pending
      @(negedge clock); check("reset_outs_a", {25'd0, outs()}, 0);
      @(negedge clock); check("reset_outs_b", {25'd0, outs()}, 0);

      // Single run, tc0=5
      #1 clear = 1'b0; gnt1_seen = 0; sb.push_back('{1'b0, 5, 5});
      @(negedge clock);
      check("single_clr", {29'd0, cnt_clr, gnt0, gnt1}, 3'b110);
      wait_done("single", 7);
      check("single_no_gnt1", {31'd0, gnt1_seen}, 0);
      #1 req0 = 1'b0;
      @(negedge clock); check("single_idle_busy", {31'd0, busy}, 0);

      // Contention after a fresh reset: order 0,1,0
      #1 clear = 1'b1;
      @(negedge clock); check("clear_idle_outs", {25'd0, outs()}, 0);
      #1 clear = 1'b0; req0 = 1'b1; req1 = 1'b1; tc0 = 4'd2; tc1 = 4'd3;
      gnt_order.delete();
      sb.push_back('{1'b0, 2, 2}); sb.push_back('{1'b1, 3, 3}); sb.push_back('{1'b0, 2, 2});
      wait_done("cont0", 5);
      wait_done("cont1", 7);
      wait_done("cont2", 6);
      #1 req0 = 1'b0; req1 = 1'b0;
      check("cont_order_len", gnt_order.size(), 3);
      if (gnt_order.size() == 3) begin
         check("cont_order_0", {31'd0, gnt_order[0]}, 0);
         check("cont_order_1", {31'd0, gnt_order[1]}, 1);
         check("cont_order_2", {31'd0, gnt_order[2]}, 0);
      end

      // tc=0: done at cycle 3, no increments
      @(negedge clock);
      #1 req1 = 1'b1; tc1 = 4'd0; sb.push_back('{1'b1, 0, 0});
      wait_done("tc_zero", 3);
      #1 req1 = 1'b0;

      // tc=15: full range, request dropped and tc changed after grant
      @(negedge clock);
      #1 req0 = 1'b1; tc0 = 4'd15; sb.push_back('{1'b0, 15, 15});
      @(negedge clock);
      #1 tc0 = 4'd3; req0 = 1'b0;
      wait_done("tc_max", 17);

      // Abort at RUN cycle 3 of tc1=9; pending req0 wins next
      @(negedge clock);
      #1 req1 = 1'b1; tc1 = 4'd9; tc0 = 4'd1;
      @(negedge clock);
      @(negedge clock);
      #1 req0 = 1'b1;
      @(negedge clock);
      @(negedge clock);
      #1 abort = 1'b1;
      @(negedge clock);
      check("abort_idle", {28'd0, busy, cnt_en, gnt1, done1}, 0);
      #1 abort = 1'b0; sb.push_back('{1'b0, 1, 1});
      @(negedge clock);
      check("abort_next_gnt", {29'd0, cnt_clr, gnt0, gnt1}, 3'b110);
      wait_done("after_abort", 3);

      // clear mid-RUN with req1 held, then clean restart
      #1 req0 = 1'b0;
      repeat (4) @(negedge clock);
      check("pre_clear_run", {30'd0, gnt1, cnt_en}, 2'b11);
      #1 clear = 1'b1;
      @(negedge clock);
      check("midrun_clear_outs", {25'd0, outs()}, 0);
      #1 clear = 1'b0; sb.push_back('{1'b1, 9, 9});
      @(negedge clock);
      check("restart_clr", {29'd0, cnt_clr, gnt0, gnt1}, 3'b101);
      wait_done("restart", 11);
      #1 req1 = 1'b0;
      repeat (3) @(negedge clock);
      check("final_busy", {31'd0, busy}, 0);
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
